// File: rtl/sd_spi_master.sv
// SPI-mode master for microSD cards: power-up clocking, then full-duplex
// DATA_W-bit transfers with programmable slow/fast SCLK dividers.
module sd_spi_master #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned DIV_SLOW    = 125,
    parameter int unsigned DIV_FAST    = 2,
    parameter int unsigned INIT_CYCLES = 80
) (
    input  logic              CLK50,
    input  logic              RST,
    input  logic              W_STB,
    input  logic [DATA_W-1:0] W_DATA,
    input  logic              FAST,
    input  logic              CS_HOLD,
    input  logic              REINIT,
    output logic              BUSY,
    output logic              INIT_DONE,
    output logic              R_VALID,
    output logic [DATA_W-1:0] R_DATA,
    output logic              MOSI,
    input  logic              MISO,
    output logic              SCLK,
    output logic              CS
);

    localparam int unsigned DIV_MAX  = (DIV_SLOW > DIV_FAST) ? DIV_SLOW : DIV_FAST;
    localparam int unsigned CW       = $clog2(DIV_MAX + 1);
    localparam int unsigned EDGE_MAX = (2 * INIT_CYCLES > 2 * DATA_W) ? 2 * INIT_CYCLES : 2 * DATA_W;
    localparam int unsigned EW       = $clog2(EDGE_MAX + 1);

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_XFER = 2'd2
    } state_t;

    state_t            state;
    logic [CW-1:0]     div_cnt;
    logic [EW-1:0]     edge_cnt;
    logic [DATA_W-1:0] tx_sh;
    logic [DATA_W-1:0] rx_sh;
    logic              fast_q;
    logic [CW-1:0]     div_lim_c;
    logic              half_c;

    // Fast divider applies only to a transfer started with FAST=1; init is always slow.
    assign div_lim_c = (state == ST_XFER && fast_q) ? CW'(DIV_FAST - 1) : CW'(DIV_SLOW - 1);
    assign half_c    = (div_cnt == div_lim_c);

    always_ff @(posedge CLK50) begin
        if (RST) begin
            state     <= ST_INIT;
            div_cnt   <= '0;
            edge_cnt  <= '0;
            tx_sh     <= '0;
            rx_sh     <= '0;
            fast_q    <= 1'b0;
            SCLK      <= 1'b0;
            CS        <= 1'b1;
            MOSI      <= 1'b1;
            R_DATA    <= '0;
            R_VALID   <= 1'b0;
            BUSY      <= 1'b1;
            INIT_DONE <= 1'b0;
        end else begin
            R_VALID <= 1'b0;
            case (state)
                ST_INIT: begin
                    if (half_c) begin
                        div_cnt <= '0;
                        SCLK    <= ~SCLK;
                        if (edge_cnt == EW'(2 * INIT_CYCLES - 1)) begin
                            edge_cnt  <= '0;
                            state     <= ST_IDLE;
                            INIT_DONE <= 1'b1;
                            BUSY      <= 1'b0;
                        end else begin
                            edge_cnt <= edge_cnt + EW'(1);
                        end
                    end else begin
                        div_cnt <= div_cnt + CW'(1);
                    end
                end
                ST_IDLE: begin
                    if (REINIT) begin
                        state     <= ST_INIT;
                        CS        <= 1'b1;
                        MOSI      <= 1'b1;
                        SCLK      <= 1'b0;
                        INIT_DONE <= 1'b0;
                        BUSY      <= 1'b1;
                        div_cnt   <= '0;
                        edge_cnt  <= '0;
                    end else if (W_STB) begin
                        state    <= ST_XFER;
                        BUSY     <= 1'b1;
                        CS       <= 1'b0;
                        SCLK     <= 1'b0;
                        MOSI     <= W_DATA[DATA_W-1];
                        tx_sh    <= {W_DATA[DATA_W-2:0], 1'b1};
                        fast_q   <= FAST;
                        div_cnt  <= '0;
                        edge_cnt <= '0;
                    end
                end
                ST_XFER: begin
                    if (half_c) begin
                        div_cnt <= '0;
                        if (!SCLK) begin
                            SCLK     <= 1'b1;
                            rx_sh    <= {rx_sh[DATA_W-2:0], MISO};
                            edge_cnt <= edge_cnt + EW'(1);
                        end else begin
                            SCLK <= 1'b0;
                            // Last falling edge completes the word and returns to idle.
                            if (edge_cnt == EW'(2 * DATA_W - 1)) begin
                                edge_cnt <= '0;
                                R_DATA   <= rx_sh;
                                R_VALID  <= 1'b1;
                                BUSY     <= 1'b0;
                                MOSI     <= 1'b1;
                                CS       <= ~CS_HOLD;
                                state    <= ST_IDLE;
                            end else begin
                                MOSI     <= tx_sh[DATA_W-1];
                                tx_sh    <= {tx_sh[DATA_W-2:0], 1'b1};
                                edge_cnt <= edge_cnt + EW'(1);
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + CW'(1);
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_spi_master.sv
// Directed bench for sd_spi_master with DIV_SLOW=4, DIV_FAST=1, INIT_CYCLES=80.
module tb_sd_spi_master;

    logic       CLK50 = 1'b0;
    logic       RST, W_STB, FAST, CS_HOLD, REINIT, MISO;
    logic [7:0] W_DATA;
    logic       BUSY, INIT_DONE, R_VALID, MOSI, SCLK, CS;
    logic [7:0] R_DATA;

    int n_vec = 0;
    int n_err = 0;

    sd_spi_master #(
        .DATA_W(8), .DIV_SLOW(4), .DIV_FAST(1), .INIT_CYCLES(80)
    ) dut (
        .CLK50(CLK50), .RST(RST), .W_STB(W_STB), .W_DATA(W_DATA), .FAST(FAST),
        .CS_HOLD(CS_HOLD), .REINIT(REINIT), .BUSY(BUSY), .INIT_DONE(INIT_DONE),
        .R_VALID(R_VALID), .R_DATA(R_DATA), .MOSI(MOSI), .MISO(MISO),
        .SCLK(SCLK), .CS(CS)
    );

    always #10 CLK50 = ~CLK50;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Runs until INIT_DONE; caller is at a falling clock edge just after init began.
    task automatic wait_init(input logic stray, output int cycles, output int rises,
                             output int bad, output int per_bad, output int rv);
        logic prev;
        cycles = 0; rises = 0; bad = 0; per_bad = 0; rv = 0; prev = 1'b0;
        do begin
            @(negedge CLK50);
            cycles++;
            if (SCLK && !prev) begin
                if (cycles != 4 + 8 * rises) per_bad++;
                rises++;
            end
            prev = SCLK;
            if (CS !== 1'b1 || MOSI !== 1'b1) bad++;
            if (R_VALID) rv++;
            W_STB  = stray && (cycles == 100 || cycles == 101 || cycles == 300);
            W_DATA = 8'hC3;
        end while (!INIT_DONE && cycles < 2000);
        W_STB = 1'b0;
    endtask

    // Starts a transfer at the current falling edge and returns in the R_VALID cycle.
    task automatic xfer(input logic [7:0] wd, input logic [7:0] pat, input logic fast,
                        input logic hold, input logic stray,
                        output logic [7:0] mosi_bits, output logic [7:0] rx,
                        output int lat, output int rises, output int cs_hi, output int hi_cyc);
        logic prev;
        W_STB = 1'b1; W_DATA = wd; FAST = fast; CS_HOLD = hold; MISO = pat[7];
        lat = 0; rises = 0; cs_hi = 0; hi_cyc = 0; mosi_bits = '0; prev = 1'b0;
        do begin
            @(negedge CLK50);
            lat++;
            W_STB = stray && (lat == 5 || lat == 9);
            if (stray) begin
                W_DATA = 8'hFF;
                FAST   = ~fast;
            end
            if (SCLK && !prev) begin
                mosi_bits = {mosi_bits[6:0], MOSI};
                rises++;
            end
            if (SCLK) hi_cyc++;
            if (!R_VALID && CS) cs_hi++;
            prev = SCLK;
            if (rises < 8) MISO = pat[7 - rises];
        end while (!R_VALID && lat < 300);
        W_STB = 1'b0;
        rx    = R_DATA;
    endtask

    initial begin
        int         cyc, ris, bad, pbad, rv, lat, lat2, csh, csh2, hic, r2, hic2;
        logic [7:0] mo, rx, mo2, rx2;

        RST = 1'b1; W_STB = 1'b0; W_DATA = '0; FAST = 1'b0; CS_HOLD = 1'b0;
        REINIT = 1'b0; MISO = 1'b0;
        repeat (3) @(negedge CLK50);

        // 1: reset state and power-up sequence
        chk("rst_sclk", 32'(SCLK), 0);
        chk("rst_cs", 32'(CS), 1);
        chk("rst_mosi", 32'(MOSI), 1);
        chk("rst_busy", 32'(BUSY), 1);
        chk("rst_init_done", 32'(INIT_DONE), 0);
        chk("rst_rvalid", 32'(R_VALID), 0);
        chk("rst_rdata", 32'(R_DATA), 0);
        RST = 1'b0;
        wait_init(1'b0, cyc, ris, bad, pbad, rv);
        chk("init_len", cyc, 640);
        chk("init_pulses", ris, 80);
        chk("init_period", pbad, 0);
        chk("init_pins", bad, 0);
        chk("init_busy", 32'(BUSY), 0);
        chk("init_sclk_low", 32'(SCLK), 0);

        // 2: single fast transfer
        @(negedge CLK50);
        chk("idle_cs", 32'(CS), 1);
        xfer(8'h40, 8'hA5, 1'b1, 1'b0, 1'b0, mo, rx, lat, ris, csh, hic);
        chk("x1_latency", lat, 17);
        chk("x1_mosi", 32'(mo), 32'h40);
        chk("x1_rdata", 32'(rx), 32'hA5);
        chk("x1_pulses", ris, 8);
        chk("x1_cs_low", csh, 0);
        chk("x1_cs_end", 32'(CS), 1);
        chk("x1_busy_end", 32'(BUSY), 0);
        @(negedge CLK50);
        chk("x1_rvalid_pulse", 32'(R_VALID), 0);
        chk("x1_rdata_hold", 32'(R_DATA), 32'hA5);

        // 3: back-to-back with CS held low
        xfer(8'hFF, 8'h3C, 1'b1, 1'b1, 1'b0, mo, rx, lat, ris, csh, hic);
        chk("b2b_cs_mid", 32'(CS), 0);
        xfer(8'h95, 8'hC3, 1'b1, 1'b1, 1'b0, mo2, rx2, lat2, r2, csh2, hic2);
        chk("b2b_mosi1", 32'(mo), 32'hFF);
        chk("b2b_rdata1", 32'(rx), 32'h3C);
        chk("b2b_mosi2", 32'(mo2), 32'h95);
        chk("b2b_rdata2", 32'(rx2), 32'hC3);
        chk("b2b_latency2", lat2, 17);
        chk("b2b_pulses", ris + r2, 16);
        chk("b2b_cs_low", csh + csh2, 0);
        chk("b2b_cs_end", 32'(CS), 0);
        CS_HOLD = 1'b0;

        // 4: strobes during init and mid-transfer are ignored
        REINIT = 1'b1;
        @(negedge CLK50);
        REINIT = 1'b0;
        chk("reinit_cs", 32'(CS), 1);
        chk("reinit_done", 32'(INIT_DONE), 0);
        chk("reinit_busy", 32'(BUSY), 1);
        wait_init(1'b1, cyc, ris, bad, pbad, rv);
        chk("reinit_len", cyc, 640);
        chk("reinit_pulses", ris, 80);
        chk("reinit_no_rvalid", rv, 0);
        xfer(8'h5A, 8'h0F, 1'b1, 1'b0, 1'b1, mo, rx, lat, ris, csh, hic);
        chk("stray_latency", lat, 17);
        chk("stray_mosi", 32'(mo), 32'h5A);
        chk("stray_rdata", 32'(rx), 32'h0F);
        rv = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK50);
            if (R_VALID) rv++;
        end
        chk("stray_no_extra", rv, 0);
        chk("stray_idle_busy", 32'(BUSY), 0);

        // 5: reset mid-transfer after the 3rd rising edge
        W_STB = 1'b1; W_DATA = 8'hC9; FAST = 1'b1; CS_HOLD = 1'b0;
        ris = 0; cyc = 0;
        begin
            logic prev;
            prev = 1'b0;
            do begin
                @(negedge CLK50);
                W_STB = 1'b0;
                cyc++;
                if (SCLK && !prev) ris++;
                prev = SCLK;
            end while (ris < 3 && cyc < 100);
        end
        chk("abort_reach3", ris, 3);
        RST = 1'b1;
        @(negedge CLK50);
        chk("abort_sclk", 32'(SCLK), 0);
        chk("abort_cs", 32'(CS), 1);
        chk("abort_mosi", 32'(MOSI), 1);
        chk("abort_busy", 32'(BUSY), 1);
        chk("abort_rdata", 32'(R_DATA), 0);
        RST = 1'b0;
        wait_init(1'b0, cyc, ris, bad, pbad, rv);
        chk("abort_no_rvalid", rv, 0);
        chk("abort_init_len", cyc, 640);

        // 6: REINIT beats W_STB; then a slow transfer
        REINIT = 1'b1; W_STB = 1'b1; W_DATA = 8'h77; FAST = 1'b1;
        @(negedge CLK50);
        REINIT = 1'b0; W_STB = 1'b0;
        chk("prio_cs", 32'(CS), 1);
        chk("prio_done", 32'(INIT_DONE), 0);
        chk("prio_busy", 32'(BUSY), 1);
        wait_init(1'b0, cyc, ris, bad, pbad, rv);
        chk("prio_no_rvalid", rv, 0);
        chk("prio_init_len", cyc, 640);
        xfer(8'h3A, 8'h69, 1'b0, 1'b0, 1'b0, mo, rx, lat, ris, csh, hic);
        chk("slow_latency", lat, 65);
        chk("slow_high_cycles", hic, 32);
        chk("slow_mosi", 32'(mo), 32'h3A);
        chk("slow_rdata", 32'(rx), 32'h69);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
